// File: rtl/equiv_stimulus_driver_if.sv
// Shared stimulus stream between the driver and both implementations under comparison.
// The driver presents data_in/input_valid; the consumer side applies stall as backpressure.
interface equiv_stimulus_driver_if #(
    parameter int unsigned DATA_WIDTH = 32
) ();
    logic [DATA_WIDTH-1:0] data_in;
    logic                  input_valid;
    logic                  stall;

    modport master (
        output data_in,
        output input_valid,
        input  stall
    );

    modport slave (
        input  data_in,
        input  input_valid,
        output stall
    );
endinterface

// File: rtl/equiv_stimulus_driver.sv
// Drive side of the sequential-equivalence harness: sequences the implementations' reset,
// issues a seeded Galois-LFSR transaction stream with gaps/stalls, drains, and reports the verdict.
module equiv_stimulus_driver #(
    parameter int unsigned           DATA_WIDTH     = 32,
    parameter int unsigned           LEN_WIDTH      = 16,
    parameter int unsigned           DUT_RST_CYCLES = 4,
    parameter int unsigned           DRAIN_CYCLES   = 20,
    parameter logic [DATA_WIDTH-1:0] LFSR_TAPS      = DATA_WIDTH'(32'h8020_0003)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] seed,
    input  logic [LEN_WIDTH-1:0]  num_txn,
    input  logic [3:0]            gap,
    input  logic                  mismatch,
    output logic                  dut_rst_n,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [LEN_WIDTH-1:0]  txn_count,
    output logic [LEN_WIDTH-1:0]  fail_index,
    equiv_stimulus_driver_if.master stim
);

    localparam int unsigned CNT_MAX = (DUT_RST_CYCLES > DRAIN_CYCLES) ? DUT_RST_CYCLES : DRAIN_CYCLES;
    localparam int unsigned CNT_W   = $clog2(((CNT_MAX > 15) ? CNT_MAX : 15) + 1);

    typedef enum logic [2:0] {
        IDLE,
        DUT_RST,
        RUN,
        GAP,
        DRAIN,
        DONE
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [DATA_WIDTH-1:0] lfsr;
    logic [DATA_WIDTH-1:0] lfsr_next;
    logic [LEN_WIDTH-1:0]  num_q;
    logic [3:0]            gap_q;
    logic                  fail;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;

    logic                  accept;
    logic                  last_accept;
    logic                  fail_hit;
    logic [LEN_WIDTH-1:0]  txn_inc;

    assign stim.data_in     = data_q;
    assign stim.input_valid = valid_q;

    always_comb begin
        lfsr_next   = (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : '0);
        accept      = (state == RUN) && valid_q && !stim.stall;
        last_accept = ({1'b0, txn_count} + (LEN_WIDTH + 1)'(1)) == {1'b0, num_q};
        txn_inc     = (&txn_count) ? txn_count : txn_count + LEN_WIDTH'(1);
        fail_hit    = ((state == RUN) || (state == GAP) || (state == DRAIN)) && mismatch && !fail;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            lfsr       <= '0;
            num_q      <= '0;
            gap_q      <= '0;
            fail       <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            dut_rst_n  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            txn_count  <= '0;
            fail_index <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        lfsr       <= (seed == '0) ? DATA_WIDTH'(1) : seed;
                        num_q      <= num_txn;
                        gap_q      <= gap;
                        txn_count  <= '0;
                        fail_index <= '0;
                        fail       <= 1'b0;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        busy       <= 1'b1;
                        dut_rst_n  <= 1'b0;
                        valid_q    <= 1'b0;
                        data_q     <= '0;
                        cnt        <= CNT_W'(DUT_RST_CYCLES);
                        state      <= DUT_RST;
                    end
                end

                DUT_RST: begin
                    if (cnt == CNT_W'(1)) begin
                        dut_rst_n <= 1'b1;
                        if (num_q == '0) begin
                            cnt   <= CNT_W'(DRAIN_CYCLES);
                            state <= DRAIN;
                        end else begin
                            valid_q <= 1'b1;
                            data_q  <= lfsr;
                            state   <= RUN;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                RUN: begin
                    if (accept) begin
                        txn_count <= txn_inc;
                        lfsr      <= lfsr_next;
                        if (last_accept) begin
                            valid_q <= 1'b0;
                            data_q  <= '0;
                            cnt     <= CNT_W'(DRAIN_CYCLES);
                            state   <= DRAIN;
                        end else if (gap_q != '0) begin
                            valid_q <= 1'b0;
                            cnt     <= CNT_W'(gap_q);
                            state   <= GAP;
                        end else begin
                            data_q <= lfsr_next;
                        end
                    end
                end

                GAP: begin
                    if (cnt == CNT_W'(1)) begin
                        valid_q <= 1'b1;
                        data_q  <= lfsr;
                        state   <= RUN;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                DRAIN: begin
                    if (cnt == CNT_W'(1)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= !fail;
                        state <= DONE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                default: state <= IDLE;
            endcase

            // Placed after the case so a first mismatch overrides any same-cycle transition,
            // while the accept bookkeeping above (txn_count, lfsr) still takes effect.
            if (fail_hit) begin
                fail       <= 1'b1;
                fail_index <= txn_count;
                valid_q    <= 1'b0;
                data_q     <= '0;
                busy       <= 1'b0;
                done       <= 1'b1;
                pass       <= 1'b0;
                state      <= DONE;
            end
        end
    end

endmodule

// File: tb/tb_equiv_stimulus_driver.sv
// Bench for equiv_stimulus_driver: directed scenarios plus randomized runs against a
// phase-level trace model (reset window, beats with stalls, gaps, drain, verdict).
module tb_equiv_stimulus_driver;

    localparam int          DW     = 32;
    localparam int          LW     = 16;
    localparam logic [31:0] TAPS   = 32'h8020_0003;
    localparam int          RSTC   = 4;
    localparam int          DRAINC = 20;
    localparam int          MAXT   = 600;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] seed;
    logic [LW-1:0] num_txn;
    logic [3:0]    gap;
    logic          mismatch;
    logic          dut_rst_n;
    logic          busy;
    logic          done;
    logic          pass;
    logic [LW-1:0] txn_count;
    logic [LW-1:0] fail_index;

    equiv_stimulus_driver_if #(.DATA_WIDTH(DW)) stim_bus ();

    equiv_stimulus_driver #(
        .DATA_WIDTH    (DW),
        .LEN_WIDTH     (LW),
        .DUT_RST_CYCLES(RSTC),
        .DRAIN_CYCLES  (DRAINC),
        .LFSR_TAPS     (TAPS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .seed      (seed),
        .num_txn   (num_txn),
        .gap       (gap),
        .mismatch  (mismatch),
        .dut_rst_n (dut_rst_n),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .txn_count (txn_count),
        .fail_index(fail_index),
        .stim      (stim_bus.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic          a_valid [MAXT];
    logic          a_rstn  [MAXT];
    logic          a_busy  [MAXT];
    logic          a_done  [MAXT];
    logic          a_pass  [MAXT];
    logic [DW-1:0] a_data  [MAXT];
    logic [LW-1:0] a_txn   [MAXT];
    logic [LW-1:0] a_fidx  [MAXT];
    int            cap_len;

    logic          stall_plan [MAXT];
    logic          mm_plan    [MAXT];

    logic          e_valid [MAXT];
    logic          e_rstn  [MAXT];
    logic          e_busy  [MAXT];
    logic          e_dchk  [MAXT];
    logic [DW-1:0] e_data  [MAXT];
    int            e_acc   [MAXT];
    int            e_end;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? TAPS : 32'h0);
    endfunction

    task automatic clear_plans();
        for (int i = 0; i < MAXT; i++) begin
            stall_plan[i] = 1'b0;
            mm_plan[i]    = 1'b0;
        end
    endtask

    // Called at a negedge; the following posedge is the start edge.
    task automatic launch(input logic [31:0] s, input logic [15:0] n, input logic [3:0] g);
        seed    = s;
        num_txn = n;
        gap     = g;
        start   = 1'b1;
    endtask

    // Sample t is taken on the negedge after the t-th posedge following the start edge.
    task automatic capture();
        cap_len = -1;
        for (int t = 0; t < MAXT; t++) begin
            @(negedge clk);
            start      = 1'b0;
            a_valid[t] = stim_bus.input_valid;
            a_data[t]  = stim_bus.data_in;
            a_rstn[t]  = dut_rst_n;
            a_busy[t]  = busy;
            a_done[t]  = done;
            a_pass[t]  = pass;
            a_txn[t]   = txn_count;
            a_fidx[t]  = fail_index;
            if (done) begin
                cap_len = t;
                break;
            end
            stim_bus.stall = stall_plan[t];
            mismatch       = mm_plan[t];
        end
        stim_bus.stall = 1'b0;
        mismatch       = 1'b0;
    endtask

    // Expected trace built from phases: reset window, each beat held while stalled, gaps, drain.
    task automatic model_trace(input logic [31:0] s, input int n, input int g);
        logic [31:0] v;
        logic        stalled;
        int          t;
        int          acc;
        for (int i = 0; i < MAXT; i++) begin
            e_valid[i] = 1'b0;
            e_rstn[i]  = (i >= RSTC);
            e_busy[i]  = 1'b1;
            e_dchk[i]  = 1'b0;
            e_data[i]  = '0;
        end
        v = (s == 0) ? 32'd1 : s;
        t = RSTC;
        for (int i = 0; i < n; i++) begin
            do begin
                e_valid[t] = 1'b1;
                e_dchk[t]  = 1'b1;
                e_data[t]  = v;
                stalled    = stall_plan[t];
                t++;
            end while (stalled && t < MAXT - DRAINC - 2);
            v = lfsr_step(v);
            if (i != n - 1) t += g;
        end
        for (int d = 0; d < DRAINC; d++) begin
            e_dchk[t] = 1'b1;
            t++;
        end
        e_end     = t;
        e_busy[t] = 1'b0;
        acc = 0;
        for (int u = 0; u <= e_end; u++) begin
            e_acc[u] = acc;
            if (e_valid[u] && !stall_plan[u]) acc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        seed = '0;
        num_txn = '0;
        gap = '0;
        mismatch = 1'b0;
        stim_bus.stall = 1'b0;
        #12;
        checks++;
        if ({dut_rst_n, stim_bus.input_valid, busy, done, pass} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got rstn=%b valid=%b busy=%b done=%b pass=%b want all 0",
                     dut_rst_n, stim_bus.input_valid, busy, done, pass);
        end
        checks++;
        if (stim_bus.data_in !== 32'h0 || txn_count !== 16'h0 || fail_index !== 16'h0) begin
            errors++;
            $display("FAIL reset_values got data=%h txn=%0d fidx=%0d want 0/0/0",
                     stim_bus.data_in, txn_count, fail_index);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || dut_rst_n !== 1'b0 || stim_bus.input_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold got busy=%b rstn=%b valid=%b want 0/0/0",
                     busy, dut_rst_n, stim_bus.input_valid);
        end
    endtask

    task automatic test_launch();
        logic [31:0] exp_beats [3];
        int lows;
        int drains;
        exp_beats[0] = 32'h0000_0001;
        exp_beats[1] = 32'h8020_0003;
        exp_beats[2] = 32'hC030_0002;
        clear_plans();
        launch(32'd1, 16'd3, 4'd0);
        capture();
        checks++;
        if (cap_len !== 27) begin
            errors++;
            $display("FAIL launch_len got %0d want 27", cap_len);
        end
        lows = 0;
        for (int t = 0; t < RSTC; t++) if (a_rstn[t] === 1'b0 && a_busy[t] === 1'b1) lows++;
        checks++;
        if (lows != RSTC || a_rstn[RSTC] !== 1'b1) begin
            errors++;
            $display("FAIL launch_rstn got low=%0d rstn_after=%b want 4/1", lows, a_rstn[RSTC]);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (a_valid[4+i] !== 1'b1 || a_data[4+i] !== exp_beats[i]) begin
                errors++;
                $display("FAIL launch_beat%0d got valid=%b data=%h want 1/%h",
                         i, a_valid[4+i], a_data[4+i], exp_beats[i]);
            end
        end
        drains = 0;
        for (int t = 7; t < 27; t++)
            if (a_valid[t] === 1'b0 && a_busy[t] === 1'b1 && a_data[t] === 32'h0) drains++;
        checks++;
        if (drains != DRAINC) begin
            errors++;
            $display("FAIL launch_drain got %0d idle cycles want %0d", drains, DRAINC);
        end
        checks++;
        if (a_done[27] !== 1'b1 || a_pass[27] !== 1'b1 || a_txn[27] !== 16'd3 || a_busy[27] !== 1'b0) begin
            errors++;
            $display("FAIL launch_final got done=%b pass=%b txn=%0d busy=%b want 1/1/3/0",
                     a_done[27], a_pass[27], a_txn[27], a_busy[27]);
        end
    endtask

    task automatic test_gap_stall();
        logic        exp_v [8];
        logic [31:0] exp_d [8];
        for (int i = 0; i < 8; i++) begin
            exp_v[i] = (i < 4) || (i == 6);
            exp_d[i] = (i < 4) ? 32'h1 : 32'h8020_0003;
        end
        clear_plans();
        for (int t = 4; t < 7; t++) stall_plan[t] = 1'b1;
        launch(32'd1, 16'd2, 4'd2);
        capture();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (a_valid[4+i] !== exp_v[i] || (exp_v[i] && a_data[4+i] !== exp_d[i])) begin
                errors++;
                $display("FAIL gap_stall_c%0d got valid=%b data=%h want %b/%h",
                         4 + i, a_valid[4+i], a_data[4+i], exp_v[i], exp_d[i]);
            end
        end
        checks++;
        if (cap_len !== 31 || a_pass[31] !== 1'b1 || a_txn[31] !== 16'd2) begin
            errors++;
            $display("FAIL gap_stall_final got len=%0d pass=%b txn=%0d want 31/1/2",
                     cap_len, a_pass[31], a_txn[31]);
        end
    endtask

    task automatic test_seed_zero();
        clear_plans();
        launch(32'd0, 16'd2, 4'd0);
        capture();
        checks++;
        if (a_data[4] !== 32'h1 || a_data[5] !== 32'h8020_0003 || a_valid[4] !== 1'b1) begin
            errors++;
            $display("FAIL seed_zero got %h %h want 00000001 80200003", a_data[4], a_data[5]);
        end
        checks++;
        if (cap_len !== 26) begin
            errors++;
            $display("FAIL seed_zero_len got %0d want 26", cap_len);
        end
    endtask

    task automatic test_num_zero();
        int beats;
        clear_plans();
        launch(32'd5, 16'd0, 4'd3);
        capture();
        beats = 0;
        for (int t = 0; t < 24; t++) if (a_valid[t] !== 1'b0) beats++;
        checks++;
        if (beats != 0 || a_rstn[3] !== 1'b0 || a_rstn[4] !== 1'b1 || a_busy[23] !== 1'b1) begin
            errors++;
            $display("FAIL num_zero_seq got beats=%0d rstn3=%b rstn4=%b busy23=%b want 0/0/1/1",
                     beats, a_rstn[3], a_rstn[4], a_busy[23]);
        end
        checks++;
        if (cap_len !== 24 || a_pass[24] !== 1'b1 || a_txn[24] !== 16'd0) begin
            errors++;
            $display("FAIL num_zero_final got len=%0d pass=%b txn=%0d want 24/1/0",
                     cap_len, a_pass[24], a_txn[24]);
        end
    endtask

    task automatic test_mismatch();
        int bad;
        clear_plans();
        mm_plan[8] = 1'b1;
        launch(32'd1, 16'd10, 4'd0);
        capture();
        checks++;
        if (a_valid[8] !== 1'b1 || a_txn[8] !== 16'd4) begin
            errors++;
            $display("FAIL mismatch_pre got valid=%b txn=%0d want 1/4", a_valid[8], a_txn[8]);
        end
        checks++;
        if (cap_len !== 9 || a_valid[9] !== 1'b0 || a_pass[9] !== 1'b0 || a_fidx[9] !== 16'd4) begin
            errors++;
            $display("FAIL mismatch_resp got len=%0d valid=%b pass=%b fidx=%0d want 9/0/0/4",
                     cap_len, a_valid[9], a_pass[9], a_fidx[9]);
        end
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (stim_bus.input_valid !== 1'b0 || done !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL mismatch_hold got %0d bad cycles want 0", bad);
        end
    endtask

    task automatic test_restart();
        int lows;
        checks++;
        if (dut_rst_n !== 1'b1 || fail_index !== 16'd4) begin
            errors++;
            $display("FAIL restart_pre got rstn=%b fidx=%0d want 1/4", dut_rst_n, fail_index);
        end
        clear_plans();
        launch(32'd1, 16'd1, 4'd0);
        capture();
        checks++;
        if (a_done[0] !== 1'b0 || a_pass[0] !== 1'b0 || a_fidx[0] !== 16'd0) begin
            errors++;
            $display("FAIL restart_clear got done=%b pass=%b fidx=%0d want 0/0/0",
                     a_done[0], a_pass[0], a_fidx[0]);
        end
        lows = 0;
        for (int t = 0; t < RSTC; t++) if (a_rstn[t] === 1'b0) lows++;
        checks++;
        if (lows != RSTC || a_rstn[RSTC] !== 1'b1) begin
            errors++;
            $display("FAIL restart_rstn got low=%0d after=%b want 4/1", lows, a_rstn[RSTC]);
        end
        checks++;
        if (cap_len !== 25 || a_pass[25] !== 1'b1) begin
            errors++;
            $display("FAIL restart_final got len=%0d pass=%b want 25/1", cap_len, a_pass[25]);
        end
    endtask

    task automatic test_reset_midrun();
        bit finished;
        launch(32'd1, 16'd8, 4'd0);
        for (int t = 0; t <= 6; t++) begin
            @(negedge clk);
            start = 1'b0;
        end
        checks++;
        if (txn_count !== 16'd2 || stim_bus.input_valid !== 1'b1) begin
            errors++;
            $display("FAIL midrun_pre got txn=%0d valid=%b want 2/1", txn_count, stim_bus.input_valid);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (stim_bus.input_valid !== 1'b0 || dut_rst_n !== 1'b0 || busy !== 1'b0 || txn_count !== 16'd0) begin
            errors++;
            $display("FAIL midrun_async got valid=%b rstn=%b busy=%b txn=%0d want 0/0/0/0",
                     stim_bus.input_valid, dut_rst_n, busy, txn_count);
        end
        @(negedge clk);
        rst = 1'b0;
        launch(32'd1, 16'd3, 4'd0);
        for (int t = 0; t <= 5; t++) begin
            @(negedge clk);
            start = 1'b0;
        end
        launch(32'h1234, 16'd1, 4'd0);
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (stim_bus.input_valid !== 1'b1 || stim_bus.data_in !== 32'hC030_0002 || dut_rst_n !== 1'b1) begin
            errors++;
            $display("FAIL busy_start_ignored got valid=%b data=%h rstn=%b want 1/c0300002/1",
                     stim_bus.input_valid, stim_bus.data_in, dut_rst_n);
        end
        finished = 1'b0;
        for (int t = 0; t < 100 && !finished; t++) begin
            @(negedge clk);
            if (done) finished = 1'b1;
        end
        checks++;
        if (!finished || txn_count !== 16'd3 || pass !== 1'b1) begin
            errors++;
            $display("FAIL busy_start_final got done=%b txn=%0d pass=%b want 1/3/1",
                     finished, txn_count, pass);
        end
    endtask

    task automatic test_random();
        logic [31:0] s;
        int n;
        int g;
        int m;
        int fail_t;
        int exp_done;
        int lim;
        int exp_fidx;
        int exp_txn;
        bit bad;
        for (int run = 0; run < 8; run++) begin
            clear_plans();
            for (int i = 0; i < MAXT; i++) stall_plan[i] = ($urandom_range(0, 99) < 30);
            s = $urandom;
            n = $urandom_range(1, 12);
            g = $urandom_range(0, 3);
            model_trace(s, n, g);
            fail_t = -1;
            if ($urandom_range(0, 1) == 1) begin
                m = $urandom_range(0, e_end - 1);
                mm_plan[m] = 1'b1;
                if (m >= RSTC) fail_t = m;
            end
            exp_done = (fail_t >= 0) ? fail_t + 1 : e_end;
            launch(s, 16'(n), 4'(g));
            capture();
            checks++;
            if (cap_len !== exp_done) begin
                errors++;
                $display("FAIL rnd%0d_len got %0d want %0d", run, cap_len, exp_done);
            end
            lim = (cap_len >= 0 && cap_len < exp_done) ? cap_len : exp_done;
            bad = 1'b0;
            for (int t = 0; t < lim && !bad; t++) begin
                checks++;
                if (a_valid[t] !== e_valid[t] || a_rstn[t] !== e_rstn[t] || a_busy[t] !== e_busy[t] ||
                    (e_dchk[t] && a_data[t] !== e_data[t]) || a_txn[t] !== 16'(e_acc[t])) begin
                    errors++;
                    bad = 1'b1;
                    $display("FAIL rnd%0d_c%0d got v=%b rn=%b b=%b d=%h txn=%0d want v=%b rn=%b b=%b d=%h txn=%0d",
                             run, t, a_valid[t], a_rstn[t], a_busy[t], a_data[t], a_txn[t],
                             e_valid[t], e_rstn[t], e_busy[t], e_data[t], e_acc[t]);
                end
            end
            if (cap_len == exp_done) begin
                exp_fidx = (fail_t >= 0) ? e_acc[fail_t] : 0;
                exp_txn  = (fail_t >= 0) ? e_acc[fail_t] + ((e_valid[fail_t] && !stall_plan[fail_t]) ? 1 : 0) : n;
                checks++;
                if (a_done[exp_done] !== 1'b1 || a_pass[exp_done] !== (fail_t < 0) ||
                    a_fidx[exp_done] !== 16'(exp_fidx) || a_txn[exp_done] !== 16'(exp_txn)) begin
                    errors++;
                    $display("FAIL rnd%0d_verdict got done=%b pass=%b fidx=%0d txn=%0d want 1/%b/%0d/%0d",
                             run, a_done[exp_done], a_pass[exp_done], a_fidx[exp_done], a_txn[exp_done],
                             (fail_t < 0), exp_fidx, exp_txn);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_launch();
        test_gap_stall();
        test_seed_zero();
        test_num_zero();
        test_mismatch();
        test_restart();
        test_reset_midrun();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
